// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the dcache slice.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL_REQ,
        FILL_WAIT,
        WR_REQ
    } dcache_state_t;

    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int lines, input int line_words);
        return addr_width - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side request port and memory-side initiator bus of the data cache.
interface dcache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  cache_rd;
    logic                  cache_wr;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wr_data;
    logic [BE_WIDTH-1:0]   cache_wr_be;
    logic [DATA_WIDTH-1:0] cache_data;
    logic                  cache_waitrequest;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [BE_WIDTH-1:0]   mem_wr_be;
    logic                  mem_waitrequest;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_valid;

    // cache view
    modport slave (
        input  cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
        output cache_data, cache_waitrequest,
        output mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
        input  mem_waitrequest, mem_rd_data, mem_rd_valid
    );

    // environment view: pipeline requester plus memory controller
    modport master (
        output cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
        input  cache_data, cache_waitrequest,
        input  mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
        output mem_waitrequest, mem_rd_data, mem_rd_valid
    );

endinterface

// File: rtl/dcache_line_ram.sv
// Byte-enabled storage array: asynchronous read, synchronous write, no reset.
module dcache_line_ram #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = WIDTH / 8
) (
    input  logic             clock,
    input  logic             we,
    input  logic [BW-1:0]    be,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < BW; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add the stat_hits / stat_misses read counters.
module dcache
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset_n,
`ifdef DCACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    dcache_if.slave     bus
);

    localparam int OFF_W = offset_bits(LINE_WORDS);
    localparam int IDX_W = index_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_WIDTH, LINES, LINE_WORDS);

    dcache_state_t state_q, state_d;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign {req_tag, req_idx, req_off} = bus.cache_addr;

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;
    logic             hit;
    assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // fill bookkeeping: line being fetched and next word to land
    logic [TAG_W-1:0] fill_tag_q;
    logic [IDX_W-1:0] fill_idx_q;
    logic [OFF_W-1:0] cnt_q, cnt_inc;
    assign cnt_inc = cnt_q + OFF_W'(1);

    logic                  mem_rd_q, mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic [BE_WIDTH-1:0]   mem_wr_be_q;

    logic                    cache_wait;
    logic                    miss_start;
    logic                    fill_done;
    logic                    ram_we;
    logic [BE_WIDTH-1:0]     ram_be;
    logic [IDX_W+OFF_W-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cache_wr)                state_d = WR_REQ;
                else if (bus.cache_rd && !hit)   state_d = FILL_REQ;
            end
            FILL_REQ:  if (!bus.mem_waitrequest) state_d = FILL_WAIT;
            FILL_WAIT: if (bus.mem_rd_valid)     state_d = (&cnt_q) ? IDLE : FILL_REQ;
            WR_REQ:    if (!bus.mem_waitrequest) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        cache_wait = 1'b0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        ram_we     = 1'b0;
        ram_be     = '0;
        ram_waddr  = {req_idx, req_off};
        ram_wdata  = bus.cache_wr_data;
        unique case (state_q)
            IDLE: begin
                cache_wait = bus.cache_wr || (bus.cache_rd && !hit);
                miss_start = !bus.cache_wr && bus.cache_rd && !hit;
            end
            FILL_REQ: cache_wait = 1'b1;
            FILL_WAIT: begin
                cache_wait = 1'b1;
                if (bus.mem_rd_valid) begin
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    ram_waddr = {fill_idx_q, cnt_q};
                    ram_wdata = bus.mem_rd_data;
                    fill_done = &cnt_q;
                end
            end
            WR_REQ: begin
                // completes in the cycle memory takes the write; only a hit touches the line
                cache_wait = bus.mem_waitrequest;
                if (!bus.mem_waitrequest && hit) begin
                    ram_we = 1'b1;
                    ram_be = bus.cache_wr_be;
                end
            end
            default: cache_wait = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            cnt_q         <= '0;
            fill_tag_q    <= '0;
            fill_idx_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_be_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cache_wr) begin
                        mem_wr_q      <= 1'b1;
                        mem_addr_q    <= bus.cache_addr;
                        mem_wr_data_q <= bus.cache_wr_data;
                        mem_wr_be_q   <= bus.cache_wr_be;
                    end else if (miss_start) begin
                        mem_rd_q         <= 1'b1;
                        mem_addr_q       <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        fill_tag_q       <= req_tag;
                        fill_idx_q       <= req_idx;
                        cnt_q            <= '0;
                        valid_q[req_idx] <= 1'b0;
                    end
                end
                FILL_REQ: if (!bus.mem_waitrequest) mem_rd_q <= 1'b0;
                FILL_WAIT: begin
                    if (bus.mem_rd_valid) begin
                        cnt_q <= cnt_inc;
                        if (fill_done) begin
                            valid_q[fill_idx_q] <= 1'b1;
                        end else begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {fill_tag_q, fill_idx_q, cnt_inc};
                        end
                    end
                end
                WR_REQ: if (!bus.mem_waitrequest) mem_wr_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (fill_done) tag_q[fill_idx_q] <= fill_tag_q;
    end

    dcache_line_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_data (
        .clock (clock),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({req_idx, req_off}),
        .rdata (bus.cache_data)
    );

    assign bus.cache_waitrequest = cache_wait;
    assign bus.mem_rd            = mem_rd_q;
    assign bus.mem_wr            = mem_wr_q;
    assign bus.mem_addr          = mem_addr_q;
    assign bus.mem_wr_data       = mem_wr_data_q;
    assign bus.mem_wr_be         = mem_wr_be_q;

`ifdef DCACHE_STATS_EN
    // the IDLE re-hit right after a fill belongs to the miss already counted
    logic refilled_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            refilled_q  <= 1'b0;
        end else begin
            refilled_q <= fill_done;
            if (state_q == IDLE && bus.cache_rd && !bus.cache_wr) begin
                if (!hit)             stat_misses <= stat_misses + 32'd1;
                else if (!refilled_q) stat_hits   <= stat_hits + 32'd1;
            end
        end
    end
`else
    // read statistics compiled out
`endif

    assert property (@(posedge clock) disable iff (!reset_n) !(bus.cache_rd && bus.cache_wr));

endmodule
